// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  output logic [7:0]                    data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int CPB    = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W  = $clog2(CPB);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Receiver state
  logic             sync1_q, sync2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push;
  logic             ferr;

  // FIFO state
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              frame_err_q, overflow_q;
  logic              empty, full, pop, wr_en, drop;

  logic rx;
  assign rx = sync2_q;

  // Two-flop synchronizer for the asynchronous line; resets to idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
    end
  end

  // Receiver FSM state registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Receiver next-state: half-bit start check, then one sample per bit period
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // Held-low line yields a single frame error; wait for release
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign pop   = !empty && data_out_ready;
  // A simultaneous pop frees the slot, so a push while full is still accepted
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // FIFO next count from accepted push/pop combination
  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write; contents need no reset since reads are gated by count
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  // FIFO pointers, count and registered event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      frame_err_q <= ferr;
      overflow_q  <= drop;
    end
  end

  assign data_out       = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign data_out_valid = !empty;
  assign fifo_count     = count_q;
  assign frame_err      = frame_err_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed table-driven bench for the UART receiver FIFO
module tb_uart_rx_fifo;

  localparam int BIT = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overflow;

  uart_rx_fifo #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (1_000_000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .fifo_count    (fifo_count),
    .frame_err     (frame_err),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fe_cnt    = 0;
  int ov_cnt    = 0;
  int both_cnt  = 0;
  logic [7:0] rx_q [$];

  // Observe accepted beats and pulses half a cycle away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (data_out_valid && data_out_ready) rx_q.push_back(data_out);
      if (frame_err) fe_cnt++;
      if (overflow) ov_cnt++;
      if (frame_err && overflow) both_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) return {24'd0, rx_q[i]};
    return 32'hDEAD;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    rx_q.delete();
    fe_cnt   = 0;
    ov_cnt   = 0;
    both_cnt = 0;
  endtask

  // Drive one frame; optionally hold the stop level longer and pulse ready on the stop-sample cycle
  task automatic send_byte(input logic [7:0] b, input logic stop, input int low_extra, input logic pulse_rdy);
    serial_in = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      cycles(BIT);
    end
    serial_in = stop;
    for (int c = 0; c < BIT; c++) begin
      if (pulse_rdy && c == 27) data_out_ready = 1'b1;
      if (pulse_rdy && c == 28) data_out_ready = 1'b0;
      cycles(1);
    end
    if (low_extra > 0) cycles(low_extra);
    serial_in = 1'b1;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         exp_beats;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{tx: 8'h61, stop: 1'b1, exp_beats: 1, exp_data: 8'h61, exp_fe: 0};
    vecs[1] = '{tx: 8'h00, stop: 1'b1, exp_beats: 1, exp_data: 8'h00, exp_fe: 0};
    vecs[2] = '{tx: 8'hFF, stop: 1'b1, exp_beats: 1, exp_data: 8'hFF, exp_fe: 0};
    vecs[3] = '{tx: 8'h80, stop: 1'b1, exp_beats: 1, exp_data: 8'h80, exp_fe: 0};
    vecs[4] = '{tx: 8'hFF, stop: 1'b0, exp_beats: 0, exp_data: 8'h00, exp_fe: 1};
    vecs[5] = '{tx: 8'h00, stop: 1'b0, exp_beats: 0, exp_data: 8'h00, exp_fe: 1};

    // Reset state
    cycles(3);
    @(negedge clk);
    check("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_count", {28'd0, fifo_count}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    cycles(1);
    rst = 1'b0;
    cycles(20);

    // Single-frame vectors with the consumer always ready
    for (int v = 0; v < 6; v++) begin
      clear_obs();
      data_out_ready = 1'b1;
      send_byte(vecs[v].tx, vecs[v].stop, 0, 1'b0);
      cycles(10);
      check($sformatf("vec%0d_beats", v), rx_q.size(), vecs[v].exp_beats);
      if (vecs[v].exp_beats == 1) check($sformatf("vec%0d_data", v), rx_at(0), {24'd0, vecs[v].exp_data});
      check($sformatf("vec%0d_ferr", v), fe_cnt, vecs[v].exp_fe);
      check($sformatf("vec%0d_ovf", v), ov_cnt, 0);
      check($sformatf("vec%0d_count", v), {28'd0, fifo_count}, 32'd0);
      check($sformatf("vec%0d_valid", v), {31'd0, data_out_valid}, 32'd0);
      cycles(20);
    end

    // Burst into a stalled consumer: two overflows, then ordered drain
    clear_obs();
    data_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'h61 + 8'(i), 1'b1, 0, 1'b0);
    cycles(10);
    check("burst_count", {28'd0, fifo_count}, 32'd8);
    check("burst_ovf", ov_cnt, 2);
    check("burst_head", {24'd0, data_out}, 32'h61);
    data_out_ready = 1'b1;
    cycles(20);
    check("burst_beats", rx_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("burst_data%0d", i), rx_at(i), 32'h61 + i);
    check("burst_valid_drop", {31'd0, data_out_valid}, 32'd0);
    check("burst_count_end", {28'd0, fifo_count}, 32'd0);
    cycles(20);

    // Glitch shorter than half a bit is rejected; next frame still decodes
    clear_obs();
    serial_in = 1'b0;
    cycles(10);
    serial_in = 1'b1;
    cycles(100);
    check("glitch_beats", rx_q.size(), 0);
    check("glitch_ferr", fe_cnt, 0);
    check("glitch_count", {28'd0, fifo_count}, 32'd0);
    send_byte(8'h5A, 1'b1, 0, 1'b0);
    cycles(10);
    check("glitch_next_beats", rx_q.size(), 1);
    check("glitch_next_data", rx_at(0), 32'h5A);
    cycles(20);

    // Framing error with the line held low three bit periods
    clear_obs();
    send_byte(8'h55, 1'b0, 2 * BIT, 1'b0);
    cycles(60);
    check("ferr_pulses", fe_cnt, 1);
    check("ferr_count", {28'd0, fifo_count}, 32'd0);
    check("ferr_beats", rx_q.size(), 0);
    send_byte(8'h41, 1'b1, 0, 1'b0);
    cycles(10);
    check("ferr_next_data", rx_at(0), 32'h41);
    check("ferr_next_beats", rx_q.size(), 1);
    cycles(20);

    // Reset during data bit 4 of 0xA5 aborts the frame silently
    clear_obs();
    serial_in = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 4; i++) begin
      serial_in = (8'hA5 >> i) & 8'h01;
      cycles(BIT);
    end
    serial_in = 1'b0;
    cycles(25);
    rst = 1'b1;
    serial_in = 1'b1;
    cycles(1);
    @(negedge clk);
    check("mrst_valid", {31'd0, data_out_valid}, 32'd0);
    check("mrst_ferr", {31'd0, frame_err}, 32'd0);
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_count", {28'd0, fifo_count}, 32'd0);
    check("mrst_data", {24'd0, data_out}, 32'd0);
    check("mrst_ovf", {31'd0, overflow}, 32'd0);
    cycles(100);
    send_byte(8'h3C, 1'b1, 0, 1'b0);
    cycles(10);
    check("mrst_beats", rx_q.size(), 1);
    check("mrst_next_data", rx_at(0), 32'h3C);
    check("mrst_pulses", fe_cnt + ov_cnt, 0);
    cycles(20);

    // Full FIFO with a pop exactly on the stop-sample cycle of a ninth byte
    clear_obs();
    data_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1, 0, 1'b0);
    cycles(5);
    check("fullpp_fill", {28'd0, fifo_count}, 32'd8);
    send_byte(8'h7E, 1'b1, 0, 1'b1);
    cycles(5);
    check("fullpp_count", {28'd0, fifo_count}, 32'd8);
    check("fullpp_ovf", ov_cnt, 0);
    check("fullpp_popped", rx_at(0), 32'h10);
    data_out_ready = 1'b1;
    cycles(20);
    check("fullpp_beats", rx_q.size(), 9);
    for (int i = 1; i < 8; i++) check($sformatf("fullpp_data%0d", i), rx_at(i), 32'h10 + i);
    check("fullpp_last", rx_at(8), 32'h7E);
    check("fullpp_count_end", {28'd0, fifo_count}, 32'd0);
    check("pulse_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- On-chip UART receiver for the host-to-FPGA serial direction. Takes the asynchronous serial line from the host (8N1, LSB first, idle high), recovers bytes by mid-bit sampling and queues them in a small first-word-fall-through FIFO.
- Software-facing side is a valid/ready byte stream read by the CPU's UART MMIO logic; the echo program drains it.
- Sits inside the RV32I system between the UART_RXD pin and the memory-mapped UART registers.

Parameters:
- CLOCK_FREQ, 50_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate; CYCLES_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division, must be >= 8).
- FIFO_DEPTH, 8, byte entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- serial_in  in  1  asynchronous RX line, idle high.
- data_out  out  8  byte at FIFO head; valid only while data_out_valid=1.
- data_out_valid  out  1  FIFO non-empty.
- data_out_ready  in  1  consumer accepts head byte when valid & ready.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of stored bytes.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset: all outputs 0 (data_out=0, fifo_count=0); synchronizer flops=1; FSM=IDLE; FIFO pointers cleared; any partial frame is discarded. Reset asserted mid-frame aborts the frame with no pulse.
- Input synchronization: 2-flop synchronizer, reset value 1. All FSM decisions use the synchronized bit.
- FSM states: IDLE, START, DATA, STOP, BREAK. Bit counter cnt counts 0..CYCLES_PER_BIT-1. Bit index idx counts 0..7.
  - IDLE: synced line = 0 -> START, cnt=0.
  - START: at cnt = CYCLES_PER_BIT/2 - 1, sample the line.
    - Sample 0 -> DATA, cnt=0, idx=0.
    - Sample 1 (glitch) -> IDLE, with no pulse and no push.
  - DATA: each time cnt = CYCLES_PER_BIT-1, sample into shift[idx], reset cnt, increment idx. After idx=7 -> STOP.
  - STOP: at cnt = CYCLES_PER_BIT-1, sample the line.
    - Sample 1 -> push byte, IDLE.
    - Sample 0 -> frame_err pulse, byte discarded, BREAK.
  - BREAK: wait for synced line = 1 -> IDLE. A held-low line therefore produces exactly one frame_err.
- Push timing: on the stop-sample cycle, the byte is written to the FIFO at that clock edge. data_out_valid rises on the next cycle when the FIFO was empty.
- Pop: data_out_valid & data_out_ready at a clock edge removes the head. The next entry appears on the following cycle; otherwise valid drops.
- FIFO full rules:
  - A push while full with no pop in the same cycle drops the new byte and pulses overflow. Stored data is unchanged.
  - A push and pop in the same cycle while full are both accepted; count stays FIFO_DEPTH, no overflow.
  - A push and pop in the same cycle while non-full and non-empty leave count unchanged.
  - A push into an empty FIFO with ready=1 is not bypassed; valid rises the next cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH and never underflows. data_out_ready while empty is ignored.
- frame_err and overflow cannot assert in the same cycle.

Test Plan:
- Single byte: CLOCK_FREQ=50M, BAUD_RATE=1M (50 cycles/bit), send 0x61 with ready=1 -> exactly one valid beat with data_out=0x61, frame_err=0, overflow=0, fifo_count returns to 0.
- Burst/overflow: FIFO_DEPTH=8, ready=0, send 0x61..0x6A back-to-back -> fifo_count=8, overflow pulses twice (for 0x69 and 0x6A); then ready=1 drains 0x61..0x68 in order and valid drops.
- Glitch rejection: drive serial_in low for 10 cycles, then high -> no push, no frame_err. A following 0x5A is received correctly.
- Framing error: send 0x55 with the stop bit low, holding the line low for 3 bit periods, then high -> one frame_err pulse, fifo_count stays 0. A subsequent 0x41 is received as 0x41.
- Reset mid-frame: assert rst for 2 cycles during data bit 4 of 0xA5 -> all outputs 0 and no pulses. Then send 0x3C -> received 0x3C only.
- Full simultaneous push/pop: fill 8 bytes, assert ready for exactly the stop-sample cycle of a ninth byte 0x7E -> no overflow, fifo_count stays 8, and 0x7E is the last byte drained.
